// File: rtl/rotate_shift_sequencer_if.sv
// Request/result handshake bundle for the iterative rotate/shift sequencer.
// The master issues ops and consumes results; the slave is the sequencer.
interface rotate_shift_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] operand;
   logic [31:0] amount;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        illegal;
   logic        busy;

   modport master (
      output in_valid, op, operand, amount, out_ready,
      input  in_ready, out_valid, result, illegal, busy
   );

   modport slave (
      input  in_valid, op, operand, amount, out_ready,
      output in_ready, out_valid, result, illegal, busy
   );
endinterface

// File: rtl/rotate_shift_sequencer.sv
// Iterative rotate/shift unit: moves the operand at most STEP bit positions per
// clock, then holds the result until the consumer takes it.
module rotate_shift_sequencer #(
   parameter int unsigned STEP = 1
) (
   input logic                      clk,
   input logic                      reset_n,
   rotate_shift_sequencer_if.slave  bus
);

   localparam logic [2:0] OpRol  = 3'b000;
   localparam logic [2:0] OpRor  = 3'b001;
   localparam logic [2:0] OpShl  = 3'b010;
   localparam logic [2:0] OpShr  = 3'b011;
   localparam logic [2:0] OpShra = 3'b100;
   localparam logic [4:0] StepAmt = 5'(STEP);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] work_q, work_d;
   logic [4:0]  rem_q, rem_d;
   logic [2:0]  op_q, op_d;
   logic        illegal_q, illegal_d;

   logic [4:0]  k;
   logic [4:0]  rem_next;
   logic [63:0] dbl;
   logic [31:0] shifted;
   logic        req_legal;

   // Only amount[4:0] matters; the upper bits are deliberately dropped.
   logic unused_amount;
   assign unused_amount = ^bus.amount[31:5];

   assign k         = (rem_q < StepAmt) ? rem_q : StepAmt;
   assign rem_next  = rem_q - k;
   assign req_legal = (bus.op <= OpShra);

   // Rotates use a doubled word so the bits leaving one end reappear at the other.
   always_comb begin
      dbl     = {work_q, work_q};
      shifted = work_q;
      case (op_q)
         OpRol: begin
            dbl     = {work_q, work_q} << k;
            shifted = dbl[63:32];
         end
         OpRor: begin
            dbl     = {work_q, work_q} >> k;
            shifted = dbl[31:0];
         end
         OpShl:   shifted = work_q << k;
         OpShr:   shifted = work_q >> k;
         OpShra:  shifted = 32'($signed(work_q) >>> k);
         default: shifted = work_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      rem_d     = rem_q;
      op_d      = op_q;
      illegal_d = illegal_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               op_d      = bus.op;
               work_d    = bus.operand;
               rem_d     = bus.amount[4:0];
               illegal_d = !req_legal;
               state_d   = (req_legal && (bus.amount[4:0] != 5'd0)) ? StRun : StDone;
            end
         end
         StRun: begin
            work_d = shifted;
            rem_d  = rem_next;
            if (rem_next == 5'd0) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         work_q    <= 32'd0;
         rem_q     <= 5'd0;
         op_q      <= 3'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         work_q    <= work_d;
         rem_q     <= rem_d;
         op_q      <= op_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.busy      = (state_q != StIdle);
   assign bus.result    = work_q;
   assign bus.illegal   = illegal_q;

endmodule

// File: doc/rotate_shift_sequencer.md
# rotate_shift_sequencer

Multi-cycle sequencer for the ALU's rotate/shift path. It accepts one operation at a time over a valid/ready handshake and steps the operand through a narrow shifter, moving at most STEP bit positions per clock. It then holds the result until the consumer takes it. It sits between the control unit's ALU-op decode and the bus result register, and replaces a full 32-way combinational rotate with a small iterative datapath.

## Interface
- STEP, default 1: maximum bit positions moved per RUN cycle; legal values are 1, 2, 4 and 8.
- clk  input  1  single clock; all state changes on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  the request fields below are valid.
- in_ready  output  1  the sequencer can accept a request; high only in IDLE.
- op  input  3  operation: 000 ROL, 001 ROR, 010 SHL, 011 SHR (logical), 100 SHRA (arithmetic); 101–111 are illegal.
- operand  input  32  value to be rotated or shifted.
- amount  input  32  shift/rotate count; only amount[4:0] is used, bits 31:5 are ignored.
- out_valid  output  1  result and illegal are valid; high only in DONE.
- out_ready  input  1  the consumer accepts the result.
- result  output  32  final value.
- illegal  output  1  the accepted op was 101–111.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On in_valid && in_ready, latch op, operand into the working register, and remaining = amount[4:0].
  - Go to RUN if remaining != 0 and op is legal; otherwise go to DONE.
- Illegal op: the working register keeps operand unchanged and illegal=1 is latched for this transaction.
- RUN, each cycle:
  - k = min(STEP, remaining).
  - Apply the op by k positions to the working register; remaining -= k.
  - Go to DONE when the new remaining is 0.
- Per-op semantics for k positions:
  - ROL: bits leaving the MSB re-enter at the LSB.
  - ROR: mirror of ROL.
  - SHL: zero fill at the LSB.
  - SHR: zero fill at the MSB.
  - SHRA: copies of bit 31 fill the vacated MSBs.
- DONE:
  - out_valid=1; result shows the working register.
  - On out_ready go to IDLE.
  - result and illegal stay stable while out_valid && !out_ready.
- Rotate by 0 leaves the value unchanged. Amounts are not reduced beyond taking bits 4:0: amount=32 behaves as 0, amount=33 as 1.
- SHL, SHR and SHRA never exceed 31 positions, so SHRA of a negative operand by 31 gives 0xFFFFFFFF.
- in_valid is ignored outside IDLE; the request fields are don't-care when in_valid=0.

## Timing
- Reset (asynchronous, any state including mid-RUN):
  - state=IDLE, working register=0, remaining=0, latched op=0, illegal=0.
  - Outputs: in_ready=1, out_valid=0, result=0, busy=0.
  - A transaction in flight is dropped without any output.
- Latency, counted from the acceptance edge to the first cycle with out_valid=1: 1 + ceil(n/STEP) cycles, where n=amount[4:0] (0 if the op is illegal).
  - n=0 gives out_valid on the cycle after acceptance.
  - STEP=1 with n=31 gives 32 cycles.
- Result handoff: the transfer occurs on the edge where out_valid && out_ready. The next cycle is IDLE with in_ready=1.
- Minimum issue interval: 2 + ceil(n/STEP) cycles.
- The result register is not back-to-back pipelined: a new request cannot be accepted in the same cycle a result is taken.
- in_ready is a registered function of state only and does not depend combinationally on in_valid.
- out_valid is also a function of state only. There is no combinational path from in_* to out_*.

## Test plan
- Rotate-left wrap, STEP=1:
  - Stimulus: reset, then accept ROL with operand=0x80000001, amount=1.
  - Required: out_valid 2 cycles after acceptance with result=0x00000003 and illegal=0; busy high for those 2 cycles.
- Rotate right with a large amount, STEP=4:
  - Stimulus: ROR with operand=0x0000000F, amount=0x00000024 (amount[4:0]=4).
  - Required: result=0xF0000000, with latency 2 cycles.
- Arithmetic shift and zero-length shift:
  - Stimulus: SHRA with operand=0x80000000, amount=31, at STEP=1 and again at STEP=8.
  - Required: result=0xFFFFFFFF; latency 32 cycles at STEP=1 and 5 cycles at STEP=8.
  - Stimulus: SHL with operand=0x12345678, amount=32.
  - Required: result=0x12345678 after 1 cycle.
- Backpressure and ignored input:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while toggling in_valid with new request data.
  - Required: result, illegal and out_valid stay stable, in_ready=0, and no new request is accepted.
  - Stimulus: raise out_ready.
  - Required: in_ready=1 on the next cycle.
- Illegal op:
  - Stimulus: op=110, operand=0xDEADBEEF, amount=5.
  - Required: result=0xDEADBEEF with illegal=1 after 1 cycle.
  - Stimulus: a following legal SHR with operand=0xDEADBEEF, amount=4.
  - Required: result=0x0DEADBEE with illegal=0.
- Reset mid-operation:
  - Stimulus: assert reset_n low asynchronously during RUN of a STEP=1, amount=20 rotate.
  - Required: outputs go to their reset values immediately with no out_valid pulse.
  - Stimulus: release reset and issue ROL with operand=0x1, amount=4.
  - Required: result=0x10.
